draw_arbiter: RTL and testbench

Sequencer and arbiter for the single VGA adapter write port. It serves two requesters: character moves from the lane state machine, and obstacle redraws from the obstacle logic. A character request erases the sprite box at the old lane and redraws it at the new lane. An obstacle request fills one sprite box. Each job completes with a one-cycle acknowledge; `DoneDrawing` is the pulse the character state machine waits on.

---
 rtl/draw_arbiter_if.sv | 29 ++
 rtl/draw_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_draw_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/draw_arbiter_if.sv
// Request/pixel bus between the two draw requesters, the arbiter and the VGA
// adapter write port.
interface draw_arbiter_if;
  logic       CharReq;
  logic [1:0] CharOld;
  logic [1:0] CharNew;
  logic       ObstReq;
  logic [1:0] ObstLane;
  logic [6:0] ObstY;
  logic       ObstErase;
  logic [7:0] X;
  logic [6:0] Y;
  logic [2:0] Colour;
  logic       Plot;
  logic       CharAck;
  logic       ObstAck;
  logic       DoneDrawing;
  logic       Busy;

  modport master (
    output CharReq, CharOld, CharNew, ObstReq, ObstLane, ObstY, ObstErase,
    input  X, Y, Colour, Plot, CharAck, ObstAck, DoneDrawing, Busy
  );

  modport slave (
    input  CharReq, CharOld, CharNew, ObstReq, ObstLane, ObstY, ObstErase,
    output X, Y, Colour, Plot, CharAck, ObstAck, DoneDrawing, Busy
  );
endinterface

// File: rtl/draw_arbiter.sv
// Round-robin arbiter and box-fill sequencer for the single VGA write port:
// character moves (erase old lane, draw new lane) and obstacle box fills.
module draw_arbiter #(
  parameter int unsigned SPRITE_W    = 8,
  parameter int unsigned SPRITE_H    = 8,
  parameter int unsigned LANE_X0     = 16,
  parameter int unsigned LANE_PITCH  = 32,
  parameter int unsigned CHAR_Y      = 100,
  parameter logic [2:0]  BG_COLOUR   = 3'b000,
  parameter logic [2:0]  CHAR_COLOUR = 3'b111,
  parameter logic [2:0]  OBST_COLOUR = 3'b100
) (
  input  logic          Clock,
  input  logic          Reset,
  draw_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    C_ERASE = 3'd1,
    C_DRAW  = 3'd2,
    O_FILL  = 3'd3,
    DONE    = 3'd4
  } state_e;

  localparam logic [3:0] PX_LAST = 4'(SPRITE_W - 1);
  localparam logic [3:0] PY_LAST = 4'(SPRITE_H - 1);
  localparam logic [7:0] X0_8    = 8'(LANE_X0);
  localparam logic [7:0] PITCH_8 = 8'(LANE_PITCH);
  localparam logic [6:0] CY_7    = 7'(CHAR_Y);

  state_e     state_q, state_d;
  logic [3:0] px_q, px_d, py_q, py_d;
  logic [1:0] old_q, old_d, new_q, new_d, olane_q, olane_d;
  logic [6:0] oy_q, oy_d;
  logic       oerase_q, oerase_d;
  logic       char_job_q, char_job_d;
  logic       last_obst_q, last_obst_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d;
  logic       char_ack_q, char_ack_d;
  logic       obst_ack_q, obst_ack_d;
  logic       busy_q, busy_d;

  logic       last_px_s, last_pix_s, char_win_s;
  logic [1:0] lane_s;
  logic [6:0] ybase_s;

  // Next-state, pixel scan and request latching
  always_comb begin
    state_d     = state_q;
    px_d        = px_q;
    py_d        = py_q;
    old_d       = old_q;
    new_d       = new_q;
    olane_d     = olane_q;
    oy_d        = oy_q;
    oerase_d    = oerase_q;
    char_job_d  = char_job_q;
    last_obst_d = last_obst_q;
    last_px_s   = (px_q == PX_LAST);
    last_pix_s  = last_px_s && (py_q == PY_LAST);
    // Character wins a tie only when the obstacle was served last
    char_win_s  = bus.CharReq && (!bus.ObstReq || last_obst_q);
    case (state_q)
      IDLE: begin
        px_d = 4'd0;
        py_d = 4'd0;
        if (char_win_s) begin
          old_d      = bus.CharOld;
          new_d      = bus.CharNew;
          char_job_d = 1'b1;
          state_d    = (bus.CharOld == bus.CharNew) ? C_DRAW : C_ERASE;
        end else if (bus.ObstReq) begin
          olane_d    = bus.ObstLane;
          oy_d       = bus.ObstY;
          oerase_d   = bus.ObstErase;
          char_job_d = 1'b0;
          state_d    = O_FILL;
        end else begin
          state_d    = IDLE;
        end
      end
      C_ERASE, C_DRAW, O_FILL: begin
        if (last_pix_s) begin
          px_d    = 4'd0;
          py_d    = 4'd0;
          state_d = (state_q == C_ERASE) ? C_DRAW : DONE;
        end else if (last_px_s) begin
          px_d = 4'd0;
          py_d = py_q + 4'd1;
        end else begin
          px_d = px_q + 4'd1;
        end
      end
      DONE: begin
        state_d     = IDLE;
        last_obst_d = !char_job_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pixel address, colour and handshakes for the cycle being entered
  always_comb begin
    case (state_d)
      C_ERASE: begin
        lane_s   = old_d;
        ybase_s  = CY_7;
        colour_d = BG_COLOUR;
        plot_d   = 1'b1;
      end
      C_DRAW: begin
        lane_s   = new_d;
        ybase_s  = CY_7;
        colour_d = CHAR_COLOUR;
        plot_d   = 1'b1;
      end
      O_FILL: begin
        lane_s   = olane_d;
        ybase_s  = oy_d;
        colour_d = oerase_d ? BG_COLOUR : OBST_COLOUR;
        plot_d   = 1'b1;
      end
      default: begin
        lane_s   = 2'd0;
        ybase_s  = 7'd0;
        colour_d = 3'b000;
        plot_d   = 1'b0;
      end
    endcase
    // Coordinates wrap silently at the screen edge
    if (plot_d) begin
      x_d = X0_8 + PITCH_8 * {6'd0, lane_s} + {4'd0, px_d};
      y_d = ybase_s + {3'd0, py_d};
    end else begin
      x_d = 8'd0;
      y_d = 7'd0;
    end
    char_ack_d = (state_d == DONE) && char_job_d;
    obst_ack_d = (state_d == DONE) && !char_job_d;
    busy_d     = (state_d != IDLE);
  end

  // State and registered outputs; reset abandons any job without an Ack
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q     <= IDLE;
      px_q        <= 4'd0;
      py_q        <= 4'd0;
      old_q       <= 2'd0;
      new_q       <= 2'd0;
      olane_q     <= 2'd0;
      oy_q        <= 7'd0;
      oerase_q    <= 1'b0;
      char_job_q  <= 1'b0;
      last_obst_q <= 1'b1;
      x_q         <= 8'd0;
      y_q         <= 7'd0;
      colour_q    <= 3'b000;
      plot_q      <= 1'b0;
      char_ack_q  <= 1'b0;
      obst_ack_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      px_q        <= px_d;
      py_q        <= py_d;
      old_q       <= old_d;
      new_q       <= new_d;
      olane_q     <= olane_d;
      oy_q        <= oy_d;
      oerase_q    <= oerase_d;
      char_job_q  <= char_job_d;
      last_obst_q <= last_obst_d;
      x_q         <= x_d;
      y_q         <= y_d;
      colour_q    <= colour_d;
      plot_q      <= plot_d;
      char_ack_q  <= char_ack_d;
      obst_ack_q  <= obst_ack_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.X           = x_q;
  assign bus.Y           = y_q;
  assign bus.Colour      = colour_q;
  assign bus.Plot        = plot_q;
  assign bus.CharAck     = char_ack_q;
  assign bus.ObstAck     = obst_ack_q;
  assign bus.DoneDrawing = char_ack_q;
  assign bus.Busy        = busy_q;

endmodule

// File: tb/tb_draw_arbiter.sv
// Self-checking bench for draw_arbiter: directed job table, multi-cycle corner
// sequences and random requests against a pixel-list reference model.
module tb_draw_arbiter;

  localparam int W = 8, H = 8, X0 = 16, P = 32, CY = 100;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  draw_arbiter_if dif();

  draw_arbiter dut (.Clock(Clock), .Reset(Reset), .bus(dif));

  always #5 Clock = ~Clock;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk_eq(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // ---------------- reference model: each job expands to a list of cycles
  typedef struct {
    bit plot; int x; int y; int c; bit cack; bit oack; bit busy;
  } exp_t;

  exp_t mq[$];
  exp_t cur;
  bit   ptr_obst = 1'b1;
  bit   mon_en = 1'b0;

  task automatic push_box(input int lane, input int ybase, input int col);
    exp_t e;
    for (int py = 0; py < H; py++)
      for (int px = 0; px < W; px++) begin
        e = '{plot:1'b1, x:(X0 + lane * P + px) % 256, y:(ybase + py) % 128,
              c:col, cack:1'b0, oack:1'b0, busy:1'b1};
        mq.push_back(e);
      end
  endtask

  task automatic push_ack(input bit is_char);
    exp_t e;
    e = '{plot:1'b0, x:0, y:0, c:0, cack:is_char, oack:!is_char, busy:1'b1};
    mq.push_back(e);
  endtask

  always @(posedge Clock) begin
    bit cw;
    if (!Reset) begin
      mq.delete();
      cur = '{default:0};
      ptr_obst = 1'b1;
    end else begin
      if (!cur.busy) begin
        cw = dif.CharReq && (!dif.ObstReq || ptr_obst);
        if (cw) begin
          if (dif.CharOld != dif.CharNew) push_box(dif.CharOld, CY, 0);
          push_box(dif.CharNew, CY, 7);
          push_ack(1'b1);
        end else if (dif.ObstReq) begin
          push_box(dif.ObstLane, dif.ObstY, dif.ObstErase ? 0 : 4);
          push_ack(1'b0);
        end
      end
      if (mq.size() > 0) begin
        cur = mq.pop_front();
        if (cur.cack) ptr_obst = 1'b0;
        if (cur.oack) ptr_obst = 1'b1;
      end else begin
        cur = '{default:0};
      end
    end
  end

  always @(negedge Clock) begin
    if (mon_en) begin
      chk_eq("mon_plot", dif.Plot, cur.plot);
      chk_eq("mon_busy", dif.Busy, cur.busy);
      chk_eq("mon_char_ack", dif.CharAck, cur.cack);
      chk_eq("mon_obst_ack", dif.ObstAck, cur.oack);
      chk_eq("mon_done_drawing", dif.DoneDrawing, cur.cack);
      if (cur.plot) begin
        chk_eq("mon_x", dif.X, cur.x);
        chk_eq("mon_y", dif.Y, cur.y);
        chk_eq("mon_colour", dif.Colour, cur.c);
      end
    end
  end

  // ---------------- directed job table
  typedef struct {
    bit creq; int cold; int cnew; bit oreq; int olane; int oy; bit oerase;
    int n_plot; int fx; int fy; int fc; int lx; int ly; int lc; int ack_cyc; bit is_char;
  } vec_t;

  vec_t tbl[6];

  task automatic wait_idle();
    int n = 0;
    while (dif.Busy && n < 400) begin
      @(negedge Clock);
      n++;
    end
    chk_eq("wait_idle", dif.Busy, 0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int nplot = 0, fx = -1, fy = -1, fc = -1, lx = -1, ly = -1, lc = -1;
    int ack_at = -1, char_acked = -1;
    bit got = 1'b0;
    dif.CharReq = v.creq;  dif.CharOld = 2'(v.cold);   dif.CharNew = 2'(v.cnew);
    dif.ObstReq = v.oreq;  dif.ObstLane = 2'(v.olane); dif.ObstY = 7'(v.oy);
    dif.ObstErase = v.oerase;
    for (int cyc = 1; cyc <= 300 && !got; cyc++) begin
      @(negedge Clock);
      if (dif.Plot) begin
        if (nplot == 0) begin fx = dif.X; fy = dif.Y; fc = dif.Colour; end
        lx = dif.X; ly = dif.Y; lc = dif.Colour;
        nplot++;
      end
      if (dif.CharAck || dif.ObstAck) begin
        got = 1'b1; ack_at = cyc; char_acked = dif.CharAck;
        dif.CharReq = 1'b0; dif.ObstReq = 1'b0;
      end
    end
    chk_eq($sformatf("v%0d_ack_seen", idx), got, 1);
    chk_eq($sformatf("v%0d_plots", idx), nplot, v.n_plot);
    chk_eq($sformatf("v%0d_first_x", idx), fx, v.fx);
    chk_eq($sformatf("v%0d_first_y", idx), fy, v.fy);
    chk_eq($sformatf("v%0d_first_c", idx), fc, v.fc);
    chk_eq($sformatf("v%0d_last_x", idx), lx, v.lx);
    chk_eq($sformatf("v%0d_last_y", idx), ly, v.ly);
    chk_eq($sformatf("v%0d_last_c", idx), lc, v.lc);
    chk_eq($sformatf("v%0d_ack_cycle", idx), ack_at, v.ack_cyc);
    chk_eq($sformatf("v%0d_ack_kind", idx), char_acked, v.is_char);
    @(negedge Clock);
    chk_eq($sformatf("v%0d_busy_after", idx), dif.Busy, 0);
  endtask

  initial begin
    int seq[3];
    int nack, cack_at, ofirst, oack_at, ox, oy, oc, fy, fc;

    tbl[0] = '{1,0,1, 0,0,0,0, 128, 16,100,0,  55,107,7, 129, 1};
    tbl[1] = '{1,2,2, 0,0,0,0,  64, 80,100,7,  87,107,7,  65, 1};
    tbl[2] = '{0,0,0, 1,3,124,0, 64, 112,124,4, 119,3,4,   65, 0};
    tbl[3] = '{0,0,0, 1,0,10,1,  64, 16,10,0,   23,17,0,   65, 0};
    tbl[4] = '{1,3,0, 0,0,0,0, 128, 112,100,0, 23,107,7,  129, 1};
    tbl[5] = '{0,0,0, 1,2,127,0, 64, 80,127,4,  87,6,4,    65, 0};

    dif.CharReq = 1'b0; dif.CharOld = 2'd0; dif.CharNew = 2'd0;
    dif.ObstReq = 1'b0; dif.ObstLane = 2'd0; dif.ObstY = 7'd0; dif.ObstErase = 1'b0;

    // power-on reset
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      mon_en = 1'b1;
      chk_eq("rst_plot", dif.Plot, 0);
      chk_eq("rst_busy", dif.Busy, 0);
      chk_eq("rst_xyc", {dif.X, dif.Y, dif.Colour}, 0);
      chk_eq("rst_acks", {dif.CharAck, dif.ObstAck, dif.DoneDrawing}, 0);
    end
    Reset = 1'b1;
    @(negedge Clock);

    // reset mid-C_DRAW, then a tie must go to the character
    dif.CharReq = 1'b1; dif.CharOld = 2'd0; dif.CharNew = 2'd1;
    repeat (80) @(negedge Clock);
    chk_eq("mid_draw_colour", dif.Colour, 7);
    Reset = 1'b0;
    dif.CharOld = 2'd1; dif.CharNew = 2'd1;
    dif.ObstReq = 1'b1; dif.ObstLane = 2'd2; dif.ObstY = 7'd50; dif.ObstErase = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      chk_eq("rst2_plot", dif.Plot, 0);
      chk_eq("rst2_busy", dif.Busy, 0);
      chk_eq("rst2_char_ack", dif.CharAck, 0);
    end
    Reset = 1'b1;
    nack = 0; fy = -1; fc = -1;
    for (int cyc = 0; cyc < 700 && nack < 3; cyc++) begin
      @(negedge Clock);
      if (dif.Plot && fy < 0) begin fy = dif.Y; fc = dif.Colour; end
      if (dif.CharAck || dif.ObstAck) begin
        seq[nack] = dif.CharAck ? 1 : 0;
        nack++;
        if (nack == 3) begin dif.CharReq = 1'b0; dif.ObstReq = 1'b0; end
      end
    end
    chk_eq("tie_ack_count", nack, 3);
    chk_eq("tie_first_y", fy, 100);
    chk_eq("tie_first_colour", fc, 7);
    chk_eq("tie_grant0_char", seq[0], 1);
    chk_eq("tie_grant1_obst", seq[1], 0);
    chk_eq("tie_grant2_char", seq[2], 1);
    dif.CharReq = 1'b0; dif.ObstReq = 1'b0;
    @(negedge Clock);
    wait_idle();

    foreach (tbl[i]) run_vec(tbl[i], i);

    // obstacle erase request raised while a character move is in progress
    cack_at = -1; ofirst = -1; oack_at = -1; ox = -1; oy = -1; oc = -1;
    dif.CharReq = 1'b1; dif.CharOld = 2'd0; dif.CharNew = 2'd3;
    for (int cyc = 1; cyc <= 400 && oack_at < 0; cyc++) begin
      @(negedge Clock);
      if (cyc == 20) begin
        dif.ObstReq = 1'b1; dif.ObstLane = 2'd1; dif.ObstY = 7'd40; dif.ObstErase = 1'b1;
      end
      if (dif.CharAck) begin cack_at = cyc; dif.CharReq = 1'b0; end
      if (dif.Plot && cack_at > 0 && ofirst < 0) begin
        ofirst = cyc; ox = dif.X; oy = dif.Y; oc = dif.Colour;
      end
      if (dif.ObstAck) begin oack_at = cyc; dif.ObstReq = 1'b0; end
    end
    chk_eq("wait_char_ack", cack_at, 129);
    chk_eq("wait_obst_first", ofirst, 131);
    chk_eq("wait_obst_x", ox, 48);
    chk_eq("wait_obst_y", oy, 40);
    chk_eq("wait_obst_colour", oc, 0);
    chk_eq("wait_obst_ack", oack_at, 195);
    @(negedge Clock);
    wait_idle();

    // random request traffic, checked by the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge Clock);
      if (dif.CharReq && dif.CharAck) begin
        dif.CharReq = 1'($urandom_range(1, 0));
        dif.CharOld = 2'($urandom_range(3, 0)); dif.CharNew = 2'($urandom_range(3, 0));
      end else if (!dif.CharReq && ($urandom_range(5, 0) == 0)) begin
        dif.CharReq = 1'b1;
        dif.CharOld = 2'($urandom_range(3, 0)); dif.CharNew = 2'($urandom_range(3, 0));
      end
      if (dif.ObstReq && dif.ObstAck) begin
        dif.ObstReq = 1'($urandom_range(1, 0));
        dif.ObstLane = 2'($urandom_range(3, 0)); dif.ObstY = 7'($urandom_range(127, 0));
        dif.ObstErase = 1'($urandom_range(1, 0));
      end else if (!dif.ObstReq && ($urandom_range(5, 0) == 0)) begin
        dif.ObstReq = 1'b1;
        dif.ObstLane = 2'($urandom_range(3, 0)); dif.ObstY = 7'($urandom_range(127, 0));
        dif.ObstErase = 1'($urandom_range(1, 0));
      end
    end
    dif.CharReq = 1'b0; dif.ObstReq = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
